// File: rtl/cpu_core.sv
// Single-cycle RV64I-subset core with private IMEM/DMEM, external memory access ports
// and a custom STOP opcode that halts execution until reset.

module cpu_regfile (
  input  logic        clk,
  input  logic        arst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [63:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [63:0] rs1_data_c,
  output logic [63:0] rs2_data_c
);
  logic [63:0] reg_array [0:31];

  // x0 is never written, so it holds its reset value of zero
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < 32; i++) reg_array[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      reg_array[waddr] <= wdata;
    end
  end

  assign rs1_data_c = (raddr1 == 5'd0) ? '0 : reg_array[raddr1];
  assign rs2_data_c = (raddr2 == 5'd0) ? '0 : reg_array[raddr2];
endmodule

module cpu_core #(
  parameter int unsigned IMEM_WORDS = 512,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        enable,
  input  logic [63:0] addr_ext,
  input  logic        wen_ext,
  input  logic        ren_ext,
  input  logic [31:0] wdata_ext,
  output logic [31:0] rdata_ext,
  input  logic [63:0] addr_ext_2,
  input  logic        wen_ext_2,
  input  logic        ren_ext_2,
  input  logic [63:0] wdata_ext_2,
  output logic [63:0] rdata_ext_2
);
  localparam int unsigned IMEM_AW = $clog2(IMEM_WORDS);
  localparam int unsigned DMEM_AW = $clog2(DMEM_WORDS);
  localparam logic [63:0] PC_MASK = 64'(IMEM_WORDS * 4 - 1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_STOP = 7'b1111110;

  logic [31:0] imem [IMEM_WORDS];
  logic [63:0] dmem [DMEM_WORDS];

  logic [63:0] pc;
  logic        halted;
  logic        active;
  logic [31:0] instruction;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_addr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] imm_i;
  logic [63:0] imm_s;
  logic [63:0] imm_b;
  logic [63:0] imm_j;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic [63:0] mem_addr;
  logic [63:0] dmem_rdata;
  logic [63:0] pc_plus4;
  logic [63:0] pc_target;
  logic [63:0] wb_data;
  logic        wb_we;
  logic        sd_we;
  logic        halt_set;
  logic        br_taken;

  logic [IMEM_AW-1:0] iext_idx;
  logic [DMEM_AW-1:0] dext_idx;
  logic [DMEM_AW-1:0] mem_idx;

  assign active      = enable && !halted;
  assign instruction = imem[pc[IMEM_AW+1:2]];
  assign opcode      = instruction[6:0];
  assign rd_addr     = instruction[11:7];
  assign funct3      = instruction[14:12];
  assign rs1_addr    = instruction[19:15];
  assign rs2_addr    = instruction[24:20];
  assign funct7      = instruction[31:25];

  assign imm_i = {{52{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{51{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j = {{43{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  cpu_regfile register_file (
    .clk        (clk),
    .arst       (arst),
    .we         (active && wb_we),
    .waddr      (rd_addr),
    .wdata      (wb_data),
    .raddr1     (rs1_addr),
    .raddr2     (rs2_addr),
    .rs1_data_c (rs1_data),
    .rs2_data_c (rs2_data)
  );

  assign pc_plus4   = pc + 64'd4;
  assign mem_addr   = rs1_data + ((opcode == OP_SD) ? imm_s : imm_i);
  assign mem_idx    = mem_addr[DMEM_AW+2:3];
  assign dmem_rdata = dmem[mem_idx];

  // Decode, execute and next-PC selection
  always_comb begin
    wb_we     = 1'b0;
    wb_data   = '0;
    sd_we     = 1'b0;
    halt_set  = 1'b0;
    br_taken  = 1'b0;
    pc_target = pc_plus4;
    case (opcode)
      OP_R: begin
        wb_we = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'h0}: wb_data = rs1_data + rs2_data;
          {7'h20, 3'h0}: wb_data = rs1_data - rs2_data;
          {7'h01, 3'h0}: wb_data = rs1_data * rs2_data;
          {7'h00, 3'h7}: wb_data = rs1_data & rs2_data;
          {7'h00, 3'h6}: wb_data = rs1_data | rs2_data;
          {7'h00, 3'h4}: wb_data = rs1_data ^ rs2_data;
          {7'h00, 3'h1}: wb_data = rs1_data << rs2_data[5:0];
          {7'h00, 3'h5}: wb_data = rs1_data >> rs2_data[5:0];
          {7'h20, 3'h5}: wb_data = 64'($signed(rs1_data) >>> rs2_data[5:0]);
          {7'h00, 3'h2}: wb_data = {63'd0, $signed(rs1_data) < $signed(rs2_data)};
          default:       wb_we   = 1'b0;
        endcase
      end
      OP_IMM: begin
        wb_we = 1'b1;
        case (funct3)
          3'h0:    wb_data = rs1_data + imm_i;
          3'h7:    wb_data = rs1_data & imm_i;
          3'h6:    wb_data = rs1_data | imm_i;
          3'h1:    wb_data = rs1_data << instruction[25:20];
          default: wb_we   = 1'b0;
        endcase
      end
      OP_LD: begin
        if (funct3 == 3'h3) begin
          wb_we   = 1'b1;
          wb_data = dmem_rdata;
        end
      end
      OP_SD: sd_we = (funct3 == 3'h3);
      OP_BR: begin
        case (funct3)
          3'h0:    br_taken = (rs1_data == rs2_data);
          3'h1:    br_taken = (rs1_data != rs2_data);
          3'h4:    br_taken = ($signed(rs1_data) < $signed(rs2_data));
          3'h5:    br_taken = ($signed(rs1_data) >= $signed(rs2_data));
          default: br_taken = 1'b0;
        endcase
        if (br_taken) pc_target = pc + imm_b;
      end
      OP_JAL: begin
        wb_we     = 1'b1;
        wb_data   = pc_plus4;
        pc_target = pc + imm_j;
      end
      OP_STOP: begin
        halt_set  = 1'b1;
        pc_target = pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pc     <= '0;
      halted <= 1'b0;
    end else if (active) begin
      pc <= pc_target & PC_MASK;
      if (halt_set) halted <= 1'b1;
    end
  end

  assign iext_idx = addr_ext[IMEM_AW+1:2];
  assign dext_idx = addr_ext_2[DMEM_AW+2:3];

  always_ff @(posedge clk) begin
    if (wen_ext) imem[iext_idx] <= wdata_ext;
  end

  // External write is issued last so it wins a same-word collision with a core SD
  always_ff @(posedge clk) begin
    if (active && sd_we) dmem[mem_idx] <= rs2_data;
    if (wen_ext_2) dmem[dext_idx] <= wdata_ext_2;
  end

  assign rdata_ext   = ren_ext   ? imem[iext_idx] : '0;
  assign rdata_ext_2 = ren_ext_2 ? dmem[dext_idx] : '0;

  logic unused;
  assign unused = ^{addr_ext[63:IMEM_AW+2], addr_ext[1:0],
                    addr_ext_2[63:DMEM_AW+3], addr_ext_2[2:0],
                    mem_addr[63:DMEM_AW+3], mem_addr[2:0]};
endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: stimulus assembles directed programs and queues expectations,
// a negedge monitor pops and compares them against the core state and external ports.

module tb_cpu_core;
  localparam int K_REG = 0, K_PC = 1, K_DMEM = 2, K_IMEM = 3, K_INSTR = 4, K_HALT = 5;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [31:0] STOP_W = 32'hA000007E;

  logic        clk = 1'b0;
  logic        arst, enable;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] wdata_ext, rdata_ext;

  typedef struct {
    int          kind;
    int          idx;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t        sb[$];
  logic [31:0] prog[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  cpu_core #(.IMEM_WORDS(512), .DMEM_WORDS(1024)) dut (
    .clk(clk), .arst(arst), .enable(enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
  );

  always @(negedge clk) begin : monitor
    chk_t        c;
    logic [63:0] act;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      case (c.kind)
        K_REG:   act = dut.register_file.reg_array[c.idx[4:0]];
        K_PC:    act = dut.pc;
        K_DMEM:  act = rdata_ext_2;
        K_IMEM:  act = {32'd0, rdata_ext};
        K_INSTR: act = {32'd0, dut.instruction};
        default: act = {63'd0, dut.halted};
      endcase
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s: got 0x%h expected 0x%h", c.name, act, c.exp);
      end
    end
  end

  function automatic void push(input int kind, input int idx, input logic [63:0] exp, input string name);
    chk_t c;
    c.kind = kind; c.idx = idx; c.exp = exp; c.name = name;
    sb.push_back(c);
  endfunction

  function automatic void exp_reg(input int r, input logic [63:0] v);
    push(K_REG, r, v, $sformatf("x%0d", r));
  endfunction

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: %0d entries pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [11:0] im = 12'(imm);
    return {im, 5'(rs1), f3, 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [11:0] im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b011, im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input int off, input int rs2, input int rs1, input logic [2:0] f3);
    logic [12:0] im = 13'(off);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input int off, input int rd);
    logic [20:0] im = 21'(off);
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
  endfunction

  function automatic void emit(input logic [31:0] w);
    prog.push_back(w);
  endfunction
  function automatic void addi(input int rd, input int rs1, input int imm);
    emit(enc_i(imm, rs1, 3'b000, rd, OP_IMM));
  endfunction
  function automatic void rop(input logic [6:0] f7, input logic [2:0] f3, input int rd, input int rs1, input int rs2);
    emit(enc_r(f7, rs2, rs1, f3, rd));
  endfunction
  function automatic void ld(input int rd, input int rs1, input int imm);
    emit(enc_i(imm, rs1, 3'b011, rd, OP_LD));
  endfunction
  function automatic void br(input logic [2:0] f3, input int rs1, input int rs2, input int target);
    emit(enc_b((target - prog.size()) * 4, rs2, rs1, f3));
  endfunction

  task automatic imem_wr(input int idx, input logic [31:0] d);
    addr_ext = 64'(idx * 4); wdata_ext = d; wen_ext = 1'b1;
    @(posedge clk); #1;
    wen_ext = 1'b0;
  endtask
  task automatic dmem_wr(input int idx, input logic [63:0] d);
    addr_ext_2 = 64'(idx * 8); wdata_ext_2 = d; wen_ext_2 = 1'b1;
    @(posedge clk); #1;
    wen_ext_2 = 1'b0;
  endtask
  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) imem_wr(i, prog[i]);
  endtask
  task automatic reset_pulse();
    arst = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0;
  endtask
  task automatic run_until_halt(input int budget);
    int n = 0;
    while (dut.halted !== 1'b1 && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (dut.halted !== 1'b1) begin
      checks++; errors++;
      $display("FAIL halt_timeout: not halted after %0d cycles, required halted", budget);
    end
  endtask
  task automatic check_dmem(input int word, input logic ren, input logic [63:0] exp, input string name);
    addr_ext_2 = 64'(word * 8); ren_ext_2 = ren;
    push(K_DMEM, word, exp, name);
    drain();
    ren_ext_2 = 1'b0;
  endtask

  initial begin
    logic [63:0] o_exp [12];
    int l_i, l_j, l_k;
    o_exp = '{64'h258, 64'h2B2, 64'h30C, 64'h1A9, 64'h1EA, 64'h22B,
              64'hFA, 64'h122, 64'h14A, 64'h4B, 64'h5A, 64'h69};
    arst = 1'b0; enable = 1'b0;
    addr_ext = '0; wen_ext = 1'b0; ren_ext = 1'b0; wdata_ext = '0;
    addr_ext_2 = '0; wen_ext_2 = 1'b0; ren_ext_2 = 1'b0; wdata_ext_2 = '0;
    #2 arst = 1'b1;
    repeat (3) @(posedge clk); #1;
    push(K_PC, 0, 64'd0, "reset_pc");
    push(K_HALT, 0, 64'd0, "reset_halted");
    drain();
    arst = 1'b0;

    // Basic ALU / load / store program
    prog.delete();
    addi(8, 0, 7); addi(9, 0, 9); ld(18, 0, 0);
    rop(7'h00, 3'h0, 19, 18, 9);
    addi(5, 0, 1); rop(7'h00, 3'h5, 21, 18, 5);
    addi(6, 0, 8); rop(7'h00, 3'h1, 22, 21, 6);
    emit(enc_i(8, 21, 3'b001, 23, OP_IMM));
    emit(enc_s(8, 9, 0)); ld(24, 0, 8);
    rop(7'h20, 3'h0, 25, 8, 9); rop(7'h00, 3'h2, 26, 25, 8);
    rop(7'h20, 3'h5, 27, 25, 5); rop(7'h00, 3'h4, 28, 8, 9);
    rop(7'h00, 3'h6, 29, 8, 9); rop(7'h00, 3'h7, 30, 8, 9);
    emit(enc_i(255, 19, 3'b111, 31, OP_IMM)); emit(enc_i(48, 8, 3'b110, 7, OP_IMM));
    addi(0, 0, 5); emit(32'h0000007F); addi(10, 0, -5);
    rop(7'h00, 3'h5, 11, 25, 5);
    emit(STOP_W);
    load_prog();
    dmem_wr(0, 64'h123456789A); dmem_wr(1, 64'h0);

    repeat (20) @(posedge clk); #1;
    push(K_PC, 0, 64'd0, "disabled_pc");
    for (int i = 0; i < 32; i++) exp_reg(i, 64'd0);
    drain();

    enable = 1'b1;
    run_until_halt(500);
    exp_reg(8, 64'h7); exp_reg(9, 64'h9); exp_reg(18, 64'h123456789A);
    exp_reg(19, 64'h12345678A3); exp_reg(21, 64'h91A2B3C4D);
    exp_reg(22, 64'h91A2B3C4D00); exp_reg(23, 64'h91A2B3C4D00);
    exp_reg(24, 64'h9); exp_reg(25, 64'hFFFFFFFFFFFFFFFE); exp_reg(26, 64'h1);
    exp_reg(27, 64'hFFFFFFFFFFFFFFFF); exp_reg(28, 64'hE); exp_reg(29, 64'hF);
    exp_reg(30, 64'h1); exp_reg(31, 64'hA3); exp_reg(7, 64'h37); exp_reg(0, 64'h0);
    exp_reg(10, 64'hFFFFFFFFFFFFFFFB); exp_reg(11, 64'h7FFFFFFFFFFFFFFF);
    drain();
    check_dmem(1, 1'b1, 64'h9, "sd_word1");

    repeat (50) @(posedge clk); #1;
    push(K_PC, 0, 64'd92, "stop_pc_held");
    push(K_INSTR, 0, {32'd0, STOP_W}, "stop_instruction_held");
    push(K_HALT, 0, 64'd1, "stop_halted");
    exp_reg(8, 64'h7); exp_reg(19, 64'h12345678A3);
    drain();

    // Branches and JAL
    enable = 1'b0; reset_pulse();
    prog.delete();
    ld(18, 0, 0); rop(7'h00, 3'h0, 20, 18, 18); addi(20, 20, 9);
    br(3'h0, 0, 0, 5); addi(20, 0, 1);
    addi(10, 0, 10); addi(11, 0, 0);
    addi(11, 11, 1); addi(10, 10, -1); br(3'h1, 10, 0, 7);
    addi(12, 0, -1);
    br(3'h4, 12, 0, 13); addi(13, 0, 5);
    br(3'h5, 0, 12, 15); addi(14, 0, 5);
    br(3'h5, 12, 0, 17); addi(15, 0, 3);
    br(3'h1, 0, 0, 19); addi(16, 0, 4);
    emit(enc_j(8, 1)); addi(17, 0, 1);
    emit(STOP_W);
    load_prog();
    enable = 1'b1;
    run_until_halt(500);
    exp_reg(20, 64'h2468ACF13D); exp_reg(10, 64'h0); exp_reg(11, 64'hA);
    exp_reg(13, 64'h0); exp_reg(14, 64'h0); exp_reg(15, 64'h3);
    exp_reg(16, 64'h4); exp_reg(1, 64'h50); exp_reg(17, 64'h0);
    drain();

    // MUL and an equivalent repeated-add loop
    enable = 1'b0; reset_pulse();
    prog.delete();
    addi(5, 0, 10); addi(6, 0, 19); rop(7'h01, 3'h0, 7, 5, 6);
    addi(8, 0, 0); addi(9, 0, 19);
    rop(7'h00, 3'h0, 8, 8, 5); addi(9, 9, -1); br(3'h1, 9, 0, 5);
    addi(10, 0, -3); rop(7'h01, 3'h0, 11, 10, 6);
    emit(STOP_W);
    load_prog();
    enable = 1'b1;
    run_until_halt(500);
    exp_reg(7, 64'hBE); exp_reg(8, 64'hBE); exp_reg(9, 64'h0);
    exp_reg(11, 64'hFFFFFFFFFFFFFFC7);
    drain();

    // Matrix product: words 0-19 hold 20..1 read as a 4x5 operand, words 20-34 hold 1..15 (5x3)
    enable = 1'b0; reset_pulse();
    prog.delete();
    addi(10, 0, 0); addi(11, 0, 280); addi(12, 0, 4);
    l_i = prog.size(); addi(13, 0, 160); addi(14, 0, 3);
    l_j = prog.size(); addi(4, 0, 0); addi(15, 10, 0); addi(16, 13, 0); addi(17, 0, 5);
    l_k = prog.size(); ld(18, 15, 0); ld(19, 16, 0);
    rop(7'h01, 3'h0, 20, 18, 19); rop(7'h00, 3'h0, 4, 4, 20);
    addi(15, 15, 8); addi(16, 16, 24); addi(17, 17, -1); br(3'h1, 17, 0, l_k);
    emit(enc_s(0, 4, 11)); addi(11, 11, 8); addi(13, 13, 8); addi(14, 14, -1);
    br(3'h1, 14, 0, l_j);
    addi(10, 10, 40); addi(12, 12, -1); br(3'h1, 12, 0, l_i);
    emit(STOP_W);
    load_prog();
    for (int w = 0; w < 20; w++) dmem_wr(w, 64'(20 - w));
    for (int w = 0; w < 15; w++) dmem_wr(20 + w, 64'(w + 1));

    addr_ext = 64'd0; ren_ext = 1'b1;
    push(K_IMEM, 0, 64'h513, "imem_ext_read");
    drain();
    ren_ext = 1'b0;
    push(K_IMEM, 0, 64'h0, "imem_ext_read_disabled");
    drain();

    enable = 1'b1;
    repeat (100) @(posedge clk); #1;
    arst = 1'b1;
    push(K_PC, 0, 64'd0, "async_reset_pc");
    exp_reg(11, 64'h0); exp_reg(12, 64'h0); exp_reg(13, 64'h0);
    drain();
    arst = 1'b0;

    run_until_halt(2000);
    for (int w = 0; w < 12; w++) check_dmem(35 + w, 1'b1, o_exp[w], $sformatf("matrix_o%0d", w));
    check_dmem(35, 1'b0, 64'h0, "dmem_ext_read_disabled");
    check_dmem(0, 1'b1, 64'd20, "matrix_input_intact");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
